// File: rtl/avr_command_issuer.sv
// Transmit side of the AVR->CPLD command link. Diffs a requested line state against the
// last-sent shadow and issues one code/strobe-toggle command per changed line, lowest line first.
module avr_command_issuer #(
   parameter int unsigned SETUP_CYC   = 2,          // legal range 1..15
   parameter int unsigned HOLD_CYC    = 2,          // legal range 1..15
   parameter logic [6:0]  SHADOW_INIT = 7'b0111010
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [6:0] req_state,
   input  logic       req_force,
   output logic [6:0] avr_ctrl,
   output logic       avr_clk,
   output logic       busy,
   output logic [6:0] shadow_state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SETUP = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC);
   localparam logic [6:0] CODE_IDLE = 7'h01;

   logic [1:0] state;
   logic [6:0] target;
   logic [6:0] pending;
   logic [6:0] shadow;
   logic [3:0] counter;
   logic [2:0] idx;
   logic [2:0] pick;

   // Line-to-code map; note we_n/counter_n/snes_mode codes are not simply 2*line+level.
   function automatic logic [6:0] cmd_code(input logic [2:0] line, input logic lvl);
      logic [6:0] c;
      case (line)
         3'd0:    c = lvl ? 7'h03 : 7'h02;
         3'd1:    c = lvl ? 7'h05 : 7'h04;
         3'd2:    c = lvl ? 7'h07 : 7'h06;
         3'd3:    c = lvl ? 7'h09 : 7'h08;
         3'd4:    c = lvl ? 7'h0C : 7'h0A;
         3'd5:    c = lvl ? 7'h0E : 7'h0D;
         3'd6:    c = lvl ? 7'h10 : 7'h0F;
         default: c = CODE_IDLE;
      endcase
      return c;
   endfunction

   always_comb begin
      pick = 3'd0;
      for (int i = 6; i >= 0; i--)
         if (pending[i]) pick = 3'(i);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         target   <= '0;
         pending  <= '0;
         shadow   <= SHADOW_INIT;
         counter  <= '0;
         idx      <= '0;
         avr_ctrl <= CODE_IDLE;
         avr_clk  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  target  <= req_state;
                  pending <= (req_state ^ shadow) | {7{req_force}};
                  state   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (pending == '0) begin
                  avr_ctrl <= CODE_IDLE;
                  state    <= ST_IDLE;
               end else begin
                  avr_ctrl      <= cmd_code(pick, target[pick]);
                  pending[pick] <= 1'b0;
                  idx           <= pick;
                  counter       <= SETUP_LD;
                  state         <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (counter == 4'd1) begin
                  // strobe level is never restored, so polarity alternates command to command
                  avr_clk     <= ~avr_clk;
                  shadow[idx] <= target[idx];
                  counter     <= HOLD_LD;
                  state       <= ST_HOLD;
               end else begin
                  counter <= counter - 4'd1;
               end
            end
            default: begin
               counter <= counter - 4'd1;
               if (counter == 4'd1) state <= ST_LOAD;
            end
         endcase
      end
   end

   assign req_ready    = (state == ST_IDLE);
   assign busy         = ~req_ready;
   assign shadow_state = shadow;

endmodule
